mips_mem_system: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/mips_mem_system_if.sv | 31 +++
 rtl/mips_mem_system_loader.sv | 65 ++++++
 rtl/mips_mem_system.sv | 82 ++++++++
 tb/tb_mips_mem_system.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory-side responder.
package mips_mem_pkg;

   localparam int unsigned WORD_W = 17;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t IO_ADDR_DEFAULT = 17'h1FFFF;

   typedef enum logic [1:0] {
      StLoad,
      StRelease,
      StRun
   } ld_state_e;

endpackage

// File: rtl/mips_mem_system_if.sv
// Core fetch/data port, boot-loader stream and IO register bundled as one interface.
interface mips_mem_system_if #(
   parameter int unsigned IMEM_AW = 8
);
   import mips_mem_pkg::*;

   word_t              pc;
   word_t              instr;
   logic               memwrite;
   word_t              aluout;
   word_t              writedata;
   word_t              readdata;
   logic               core_reset;
   logic               ld_valid;
   logic               ld_ready;
   word_t              ld_data;
   logic               ld_last;
   logic [IMEM_AW:0]   ld_count;
   word_t              io_out;

   modport slave (
      input  pc, memwrite, aluout, writedata, ld_valid, ld_data, ld_last,
      output instr, readdata, core_reset, ld_ready, ld_count, io_out
   );

   modport master (
      output pc, memwrite, aluout, writedata, ld_valid, ld_data, ld_last,
      input  instr, readdata, core_reset, ld_ready, ld_count, io_out
   );

endinterface

// File: rtl/mips_mem_system_loader.sv
// Boot loader: fills instruction memory from a valid/ready stream, then releases the core.
module mem_loader
   import mips_mem_pkg::*;
#(
   parameter int unsigned IMEM_AW = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_valid_i,
   input  logic               ld_last_i,
   output logic               ld_ready_o,
   output logic               core_reset_o,
   output logic               run_o,
   output logic               imem_we_o,
   output logic [IMEM_AW-1:0] imem_waddr_o,
   output logic [IMEM_AW:0]   ld_count_o
);

   localparam logic [IMEM_AW:0] LastIdx = {1'b0, {IMEM_AW{1'b1}}};

   ld_state_e        state_q, state_d;
   logic [IMEM_AW:0] count_q, count_d;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      ld_ready_o   = 1'b0;
      core_reset_o = 1'b1;
      run_o        = 1'b0;
      imem_we_o    = 1'b0;
      unique case (state_q)
         StLoad: begin
            ld_ready_o = 1'b1;
            if (ld_valid_i) begin
               imem_we_o = 1'b1;
               count_d   = count_q + 1'b1;
               // A full memory ends the load even without ld_last.
               if (ld_last_i || count_q == LastIdx) begin
                  state_d = StRelease;
               end
            end
         end
         StRelease: state_d = StRun;
         StRun: begin
            core_reset_o = 1'b0;
            run_o        = 1'b1;
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StLoad;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign imem_waddr_o = count_q[IMEM_AW-1:0];
   assign ld_count_o   = count_q;

endmodule

// File: rtl/mips_mem_system.sv
// Instruction/data memories, IO register and read muxes serving the 17-bit MIPS core.
module mips_mem_system
   import mips_mem_pkg::*;
#(
   parameter int unsigned IMEM_AW = 8,
   parameter int unsigned DMEM_AW = 8,
   parameter word_t       IO_ADDR = IO_ADDR_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   mips_mem_system_if.slave  bus
);

   localparam int unsigned IDepth = 1 << IMEM_AW;
   localparam int unsigned DDepth = 1 << DMEM_AW;

   word_t imem [IDepth];
   word_t dmem [DDepth];

   logic               run;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_waddr;
   logic               pc_in_range;
   logic               dm_in_range;
   logic               io_hit;
   logic               io_we;
   logic               dmem_we;
   word_t              io_q, io_d;

   mem_loader #(
      .IMEM_AW(IMEM_AW)
   ) u_loader (
      .clk          (clk),
      .reset        (reset),
      .ld_valid_i   (bus.ld_valid),
      .ld_last_i    (bus.ld_last),
      .ld_ready_o   (bus.ld_ready),
      .core_reset_o (bus.core_reset),
      .run_o        (run),
      .imem_we_o    (imem_we),
      .imem_waddr_o (imem_waddr),
      .ld_count_o   (bus.ld_count)
   );

   always_comb begin
      pc_in_range = (bus.pc >> IMEM_AW) == '0;
      dm_in_range = (bus.aluout >> DMEM_AW) == '0;
      io_hit      = bus.aluout == IO_ADDR;
      io_we       = run && bus.memwrite && io_hit;
      dmem_we     = run && bus.memwrite && !io_hit && dm_in_range;
      io_d        = io_we ? bus.writedata : io_q;
      bus.instr   = pc_in_range ? imem[bus.pc[IMEM_AW-1:0]] : '0;
      // IO register shadows any data word that happens to share its address.
      if (io_hit) begin
         bus.readdata = io_q;
      end else if (dm_in_range) begin
         bus.readdata = dmem[bus.aluout[DMEM_AW-1:0]];
      end else begin
         bus.readdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_waddr] <= bus.ld_data;
      end
      if (dmem_we) begin
         dmem[bus.aluout[DMEM_AW-1:0]] <= bus.writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         io_q <= '0;
      end else begin
         io_q <= io_d;
      end
   end

   assign bus.io_out = io_q;

endmodule

// File: tb/tb_mips_mem_system.sv
// Directed bench for mips_mem_system with a cycle-level reference model checked every cycle.
module tb_mips_mem_system;
   import mips_mem_pkg::*;

   localparam int unsigned IAW = 8;
   localparam int unsigned DAW = 8;
   localparam int unsigned ID  = 1 << IAW;
   localparam int unsigned DD  = 1 << DAW;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips_mem_system_if #(.IMEM_AW(IAW)) bus ();

   mips_mem_system #(
      .IMEM_AW(IAW),
      .DMEM_AW(DAW),
      .IO_ADDR(17'h1FFFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: loading flag, edges since the final accept, plain arrays.
   bit          m_loading = 1'b1;
   int          m_after   = 0;
   int          m_count   = 0;
   logic [16:0] m_io      = '0;
   logic [16:0] m_imem [ID];
   bit          m_iv   [ID];
   logic [16:0] m_dmem [DD];
   bit          m_dv   [DD];

   function automatic bit m_run();
      return !m_loading && m_after >= 1;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_loading <= 1'b1;
         m_after   <= 0;
         m_count   <= 0;
         m_io      <= '0;
      end else if (m_loading) begin
         if (bus.ld_valid) begin
            m_imem[m_count] <= bus.ld_data;
            m_iv[m_count]   <= 1'b1;
            m_count         <= m_count + 1;
            if (bus.ld_last || m_count == ID - 1) m_loading <= 1'b0;
         end
      end else begin
         if (m_after < 2) m_after <= m_after + 1;
         if (m_after >= 1 && bus.memwrite) begin
            if (bus.aluout == 17'h1FFFF) begin
               m_io <= bus.writedata;
            end else if (bus.aluout < DD) begin
               m_dmem[bus.aluout[DAW-1:0]] <= bus.writedata;
               m_dv[bus.aluout[DAW-1:0]]   <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("m_core_reset", 32'(bus.core_reset), 32'(!m_run()));
         chk("m_ld_ready", 32'(bus.ld_ready), 32'(m_loading));
         chk("m_ld_count", 32'(bus.ld_count), 32'(m_count));
         chk("m_io_out", 32'(bus.io_out), 32'(m_io));
         if (bus.pc >= ID) begin
            chk("m_instr_oor", 32'(bus.instr), 32'd0);
         end else if (m_iv[bus.pc[IAW-1:0]]) begin
            chk("m_instr", 32'(bus.instr), 32'(m_imem[bus.pc[IAW-1:0]]));
         end
         if (bus.aluout == 17'h1FFFF) begin
            chk("m_readdata_io", 32'(bus.readdata), 32'(m_io));
         end else if (bus.aluout >= DD) begin
            chk("m_readdata_oor", 32'(bus.readdata), 32'd0);
         end else if (m_dv[bus.aluout[DAW-1:0]]) begin
            chk("m_readdata", 32'(bus.readdata), 32'(m_dmem[bus.aluout[DAW-1:0]]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] fill_word(input int i);
      return 17'(i * 37) ^ 17'h15A5A;
   endfunction

   logic [16:0] prog [3] = '{17'h01234, 17'h05678, 17'h09ABC};

   initial begin
      bus.pc        = '0;
      bus.memwrite  = 1'b0;
      bus.aluout    = '0;
      bus.writedata = '0;
      bus.ld_valid  = 1'b0;
      bus.ld_data   = '0;
      bus.ld_last   = 1'b0;
      reset         = 1'b1;
      cyc();
      cyc();
      check_en = 1'b1;
      reset    = 1'b0;
      @(negedge clk);
      chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("rst_ld_count", 32'(bus.ld_count), 32'd0);
      chk("rst_io_out", 32'(bus.io_out), 32'd0);
      cyc();

      // Three-word program with ld_last on the final word.
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = prog[i];
         bus.ld_last  = (i == 2);
         cyc();
      end
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      @(negedge clk);
      chk("ld3_count", 32'(bus.ld_count), 32'd3);
      chk("ld3_release_core_reset", 32'(bus.core_reset), 32'd1);
      chk("ld3_release_ready", 32'(bus.ld_ready), 32'd0);
      cyc();
      bus.pc = 17'd1;
      @(negedge clk);
      chk("run_core_reset", 32'(bus.core_reset), 32'd0);
      chk("instr_pc1", 32'(bus.instr), 32'h05678);
      cyc();

      // Data store, load-after-store and same-cycle read.
      bus.memwrite  = 1'b1;
      bus.aluout    = 17'h10;
      bus.writedata = 17'h1ABCD;
      cyc();
      bus.memwrite = 1'b0;
      @(negedge clk);
      chk("dmem_rd_10", 32'(bus.readdata), 32'h1ABCD);
      cyc();
      bus.memwrite  = 1'b1;
      bus.writedata = 17'h0AAAA;
      @(negedge clk);
      chk("dmem_same_cycle_old", 32'(bus.readdata), 32'h1ABCD);
      cyc();
      bus.memwrite = 1'b0;
      @(negedge clk);
      chk("dmem_rd_10_new", 32'(bus.readdata), 32'h0AAAA);
      cyc();

      // IO register and an out-of-range store.
      bus.memwrite  = 1'b1;
      bus.aluout    = 17'h1FFFF;
      bus.writedata = 17'h00055;
      cyc();
      bus.memwrite = 1'b0;
      @(negedge clk);
      chk("io_out_55", 32'(bus.io_out), 32'h00055);
      chk("io_readback", 32'(bus.readdata), 32'h00055);
      cyc();
      bus.memwrite  = 1'b1;
      bus.aluout    = 17'h00400;
      bus.writedata = 17'h00777;
      cyc();
      bus.memwrite = 1'b0;
      @(negedge clk);
      chk("oor_readdata", 32'(bus.readdata), 32'd0);
      chk("oor_io_kept", 32'(bus.io_out), 32'h00055);
      cyc();

      // Loader stream is ignored once running.
      bus.ld_valid = 1'b1;
      bus.ld_data  = 17'h1FFFF;
      bus.ld_last  = 1'b1;
      cyc();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      @(negedge clk);
      chk("run_ld_ignored_count", 32'(bus.ld_count), 32'd3);
      chk("run_ld_ignored_instr", 32'(bus.instr), 32'h05678);
      cyc();

      // Reset pulse while running.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("rerst_core_reset", 32'(bus.core_reset), 32'd1);
      chk("rerst_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("rerst_ld_count", 32'(bus.ld_count), 32'd0);
      chk("rerst_io_out", 32'(bus.io_out), 32'd0);
      chk("rerst_imem_kept", 32'(bus.instr), 32'h05678);
      cyc();

      // Stores during LOAD are ignored; fetch above imem is a nop.
      bus.memwrite  = 1'b1;
      bus.aluout    = 17'h10;
      bus.writedata = 17'h00F0F;
      bus.pc        = 17'h00100;
      cyc();
      bus.memwrite = 1'b0;
      @(negedge clk);
      chk("pc_oor_instr", 32'(bus.instr), 32'd0);
      chk("load_io_unchanged", 32'(bus.io_out), 32'd0);
      cyc();

      // Fill the whole instruction memory without ld_last.
      for (int i = 0; i < int'(ID); i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = fill_word(i);
         cyc();
      end
      bus.ld_data = 17'h1FFFF;
      @(negedge clk);
      chk("full_count", 32'(bus.ld_count), 32'd256);
      chk("full_ready", 32'(bus.ld_ready), 32'd0);
      chk("full_release", 32'(bus.core_reset), 32'd1);
      cyc();
      bus.ld_valid = 1'b0;
      bus.pc       = 17'h000FF;
      @(negedge clk);
      chk("full_count_sat", 32'(bus.ld_count), 32'd256);
      chk("full_run", 32'(bus.core_reset), 32'd0);
      chk("full_instr_ff", 32'(bus.instr), 32'h17E81);
      chk("dmem_kept_over_load", 32'(bus.readdata), 32'h0AAAA);
      cyc();
      bus.pc = 17'd1;
      @(negedge clk);
      chk("full_instr_1", 32'(bus.instr), 32'h15A7F);
      cyc();

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
